// File: rtl/dot_int_seq_pkg.sv
// Shared types, default parameters and width helpers for the dot-product sequencer.
package dot_seq_pkg;

    localparam int BIT_WIDTH_DEF  = 8;
    localparam int K_DEF          = 32;
    localparam int MAX_BLOCKS_DEF = 64;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } seq_state_e;

    function automatic int dp_width_f(input int bw, input int lanes);
        return 2 * bw + $clog2(lanes);
    endfunction

    function automatic int acc_width_f(input int bw, input int lanes, input int mb);
        return dp_width_f(bw, lanes) + $clog2(mb);
    endfunction

endpackage

// File: rtl/dot_int.sv
// Combinational k-lane signed integer dot product, full precision.
module dot_int
    import dot_seq_pkg::*;
#(
    parameter int bit_width = BIT_WIDTH_DEF,
    parameter int k         = K_DEF,
    localparam int dp_width = dp_width_f(bit_width, k)
) (
    input  logic [k-1:0][bit_width-1:0] i_a,
    input  logic [k-1:0][bit_width-1:0] i_b,
    output logic signed [dp_width-1:0]  o_dp
);

    localparam int prod_width = 2 * bit_width;

    logic signed [prod_width-1:0] prod [k];

    always_comb begin
        o_dp = '0;
        for (int i = 0; i < k; i++) begin
            prod[i] = $signed(i_a[i]) * $signed(i_b[i]);
            o_dp    = o_dp + {{(dp_width - prod_width){prod[i][prod_width-1]}}, prod[i]};
        end
    end

endmodule

// File: rtl/dot_seq_acc.sv
// Stage 2 register for the lane dot product plus the running accumulator and result capture.
module dot_seq_acc #(
    parameter int dp_width  = 21,
    parameter int acc_width = 27
) (
    input  logic                        i_clk,
    input  logic                        i_rst_n,
    input  logic                        i_clr,
    input  logic                        i_valid,
    input  logic                        i_last,
    input  logic signed [dp_width-1:0]  i_dp,
    output logic                        o_res_load,
    output logic signed [acc_width-1:0] o_res
);

    logic                        s2_valid;
    logic                        s2_last;
    logic signed [dp_width-1:0]  s2_dp;
    logic signed [acc_width-1:0] acc;
    logic signed [acc_width-1:0] sum;

    assign sum        = acc + {{(acc_width - dp_width){s2_dp[dp_width-1]}}, s2_dp};
    assign o_res_load = s2_valid & s2_last;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            s2_valid <= 1'b0;
            s2_last  <= 1'b0;
            s2_dp    <= '0;
            acc      <= '0;
            o_res    <= '0;
        end else begin
            s2_valid <= i_valid;
            s2_last  <= i_valid & i_last;
            if (i_valid)
                s2_dp <= i_dp;
            if (i_clr)
                acc <= '0;
            else if (s2_valid)
                acc <= sum;
            // Result register holds until the next command's last block lands.
            if (o_res_load)
                o_res <= sum;
        end
    end

endmodule

// File: rtl/dot_int_seq.sv
// Sequencer streaming operand blocks through dot_int and accumulating one wide result per command.
//   state | meaning
//   IDLE  | waiting for i_start
//   RUN   | accepting operand blocks until block n is taken
//   DRAIN | no new blocks; waiting for the last block to reach the accumulator
//   DONE  | result presented until i_res_ready
module dot_int_seq
    import dot_seq_pkg::*;
#(
    parameter int bit_width  = BIT_WIDTH_DEF,
    parameter int k          = K_DEF,
    parameter int max_blocks = MAX_BLOCKS_DEF,
    localparam int dp_width  = dp_width_f(bit_width, k),
    localparam int acc_width = acc_width_f(bit_width, k, max_blocks),
    localparam int nb_width  = $clog2(max_blocks)
) (
    input  logic                          i_clk,
    input  logic                          i_rst_n,
    input  logic                          i_start,
    input  logic [nb_width-1:0]           i_n_blocks,
    output logic                          o_busy,
    input  logic                          i_op_valid,
    output logic                          o_op_ready,
    input  logic [k-1:0][bit_width-1:0]   i_op0,
    input  logic [k-1:0][bit_width-1:0]   i_op1,
    output logic                          o_res_valid,
    input  logic                          i_res_ready,
    output logic signed [acc_width-1:0]   o_res
);

    localparam int cnt_width = nb_width + 1;

    localparam logic [1:0] S_IDLE  = ST_IDLE;
    localparam logic [1:0] S_RUN   = ST_RUN;
    localparam logic [1:0] S_DRAIN = ST_DRAIN;
    localparam logic [1:0] S_DONE  = ST_DONE;

    logic [1:0]                   state;
    logic [cnt_width-1:0]         n_blocks;
    logic [cnt_width-1:0]         acc_cnt;
    logic                         accept;
    logic                         last_blk;
    logic                         clr;
    logic                         res_load;
    logic                         s1_valid;
    logic                         s1_last;
    logic [k-1:0][bit_width-1:0]  s1_op0;
    logic [k-1:0][bit_width-1:0]  s1_op1;
    logic signed [dp_width-1:0]   dp;

    assign o_busy      = (state != S_IDLE);
    assign o_op_ready  = (state == S_RUN);
    assign o_res_valid = (state == S_DONE);
    assign accept      = i_op_valid & o_op_ready;
    assign last_blk    = (acc_cnt + cnt_width'(1)) == n_blocks;
    assign clr         = (state == S_IDLE) & i_start;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state    <= S_IDLE;
            n_blocks <= '0;
            acc_cnt  <= '0;
        end else begin
            case (state)
                S_IDLE: if (i_start) begin
                    // A zero block count encodes the full max_blocks length.
                    n_blocks <= (i_n_blocks == '0) ? cnt_width'(max_blocks) : {1'b0, i_n_blocks};
                    acc_cnt  <= '0;
                    state    <= S_RUN;
                end
                S_RUN: if (accept) begin
                    acc_cnt <= acc_cnt + cnt_width'(1);
                    if (last_blk)
                        state <= S_DRAIN;
                end
                S_DRAIN: if (res_load)
                    state <= S_DONE;
                S_DONE: if (i_res_ready)
                    state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            s1_valid <= 1'b0;
            s1_last  <= 1'b0;
            s1_op0   <= '0;
            s1_op1   <= '0;
        end else begin
            s1_valid <= accept;
            s1_last  <= accept & last_blk;
            if (accept) begin
                s1_op0 <= i_op0;
                s1_op1 <= i_op1;
            end
        end
    end

    dot_int #(
        .bit_width (bit_width),
        .k         (k)
    ) u_dot (
        .i_a  (s1_op0),
        .i_b  (s1_op1),
        .o_dp (dp)
    );

    dot_seq_acc #(
        .dp_width  (dp_width),
        .acc_width (acc_width)
    ) u_acc (
        .i_clk      (i_clk),
        .i_rst_n    (i_rst_n),
        .i_clr      (clr),
        .i_valid    (s1_valid),
        .i_last     (s1_last),
        .i_dp       (dp),
        .o_res_load (res_load),
        .o_res      (o_res)
    );

endmodule

// File: tb/tb_dot_int_seq.sv
// Randomised and directed bench for dot_int_seq against a plain-arithmetic dot-product model.
module tb_dot_int_seq;

    localparam int BW   = 8;
    localparam int K    = 32;
    localparam int MB   = 64;
    localparam int ACCW = 27;

    logic                     i_clk = 1'b0;
    logic                     i_rst_n = 1'b0;
    logic                     i_start = 1'b0;
    logic [5:0]               i_n_blocks = '0;
    logic                     o_busy;
    logic                     i_op_valid = 1'b0;
    logic                     o_op_ready;
    logic [K-1:0][BW-1:0]     i_op0 = '0;
    logic [K-1:0][BW-1:0]     i_op1 = '0;
    logic                     o_res_valid;
    logic                     i_res_ready = 1'b0;
    logic signed [ACCW-1:0]   o_res;

    int total = 0;
    int bad   = 0;

    logic signed [BW-1:0] blk_a [MB][K];
    logic signed [BW-1:0] blk_b [MB][K];

    dot_int_seq u_dut (
        .i_clk       (i_clk),
        .i_rst_n     (i_rst_n),
        .i_start     (i_start),
        .i_n_blocks  (i_n_blocks),
        .o_busy      (o_busy),
        .i_op_valid  (i_op_valid),
        .o_op_ready  (o_op_ready),
        .i_op0       (i_op0),
        .i_op1       (i_op1),
        .o_res_valid (o_res_valid),
        .i_res_ready (i_res_ready),
        .o_res       (o_res)
    );

    always #5 i_clk = ~i_clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic longint model_dot(input int n);
        longint s = 0;
        for (int b = 0; b < n; b++)
            for (int l = 0; l < K; l++)
                s += longint'(blk_a[b][l]) * longint'(blk_b[b][l]);
        return s;
    endfunction

    task automatic fill_const(input int a, input int b);
        for (int i = 0; i < MB; i++)
            for (int l = 0; l < K; l++) begin
                blk_a[i][l] = BW'(a);
                blk_b[i][l] = BW'(b);
            end
    endtask

    task automatic fill_rand();
        for (int i = 0; i < MB; i++)
            for (int l = 0; l < K; l++) begin
                blk_a[i][l] = BW'($urandom);
                blk_b[i][l] = BW'($urandom);
            end
    endtask

    task automatic drive_ops(input int b, input bit v);
        i_op_valid = v;
        for (int l = 0; l < K; l++) begin
            i_op0[l] = v ? blk_a[b][l] : BW'($urandom);
            i_op1[l] = v ? blk_b[b][l] : BW'($urandom);
        end
    endtask

    // Runs one command; garbage with i_op_valid high is kept on the bus while not ready.
    task automatic do_cmd(input int n_enc, input int gap, input int hold, input bit poke_start,
                          output longint res, output int accepts, output int lat,
                          output int rdy_err, output int stab_err, output int idle_err);
        int n;
        int cyc;
        bit v;
        bit rdy;
        n = (n_enc == 0) ? MB : n_enc;
        accepts = 0; lat = 0; rdy_err = 0; stab_err = 0; idle_err = 0; res = 0;
        @(negedge i_clk);
        i_start = 1'b1;
        i_n_blocks = 6'(n_enc);
        @(negedge i_clk);
        i_start = 1'b0;
        i_n_blocks = 6'($urandom);
        cyc = 0;
        while (accepts < n && cyc < 1000) begin
            case (gap)
                0: v = 1'b1;
                1: v = (cyc % 2 == 0);
                default: v = 1'($urandom_range(0, 1));
            endcase
            drive_ops(accepts, v);
            rdy = o_op_ready;
            if (!o_op_ready || !o_busy) rdy_err++;
            @(posedge i_clk);
            if (v && rdy) accepts++;
            cyc++;
            @(negedge i_clk);
        end
        drive_ops(0, 1'b0);
        i_op_valid = 1'b1;
        lat = 1;
        while (!o_res_valid && lat < 50) begin
            if (o_op_ready || !o_busy) rdy_err++;
            @(negedge i_clk);
            lat++;
        end
        res = longint'(o_res);
        for (int i = 0; i < hold; i++) begin
            i_start = poke_start && (i == hold / 2);
            i_n_blocks = 6'd1;
            @(negedge i_clk);
            i_start = 1'b0;
            if (!o_res_valid || longint'(o_res) != res || !o_busy || o_op_ready) stab_err++;
        end
        i_res_ready = 1'b1;
        @(negedge i_clk);
        i_res_ready = 1'b0;
        i_op_valid = 1'b0;
        if (o_res_valid || o_busy || o_op_ready || longint'(o_res) != res) idle_err++;
    endtask

    task automatic test_reset();
        i_rst_n = 1'b0;
        #1;
        total++;
        if (o_busy !== 1'b0 || o_op_ready !== 1'b0 || o_res_valid !== 1'b0) begin
            bad++;
            $display("FAIL reset_flags: busy=%b ready=%b valid=%b want 000", o_busy, o_op_ready, o_res_valid);
        end
        total++;
        if (o_res !== '0) begin
            bad++;
            $display("FAIL reset_res: got %0d want 0", o_res);
        end
        @(negedge i_clk);
        i_rst_n = 1'b1;
        @(negedge i_clk);
        total++;
        if (o_busy !== 1'b0 || o_op_ready !== 1'b0) begin
            bad++;
            $display("FAIL idle_flags: busy=%b ready=%b want 00", o_busy, o_op_ready);
        end
    endtask

    task automatic test_single();
        longint res; int acc, lat, re, se, ie;
        fill_const(1, 1);
        do_cmd(1, 0, 0, 1'b0, res, acc, lat, re, se, ie);
        total++;
        if (res != 64'sd32) begin bad++; $display("FAIL single_res: got %0d want 32", res); end
        total++;
        if (lat != 3) begin bad++; $display("FAIL single_latency: got %0d want 3", lat); end
        total++;
        if (re != 0 || ie != 0) begin bad++; $display("FAIL single_ready: errs %0d/%0d want 0/0", re, ie); end
    endtask

    task automatic test_neg_full();
        longint res; int acc, lat, re, se, ie;
        fill_const(-128, -128);
        do_cmd(4, 0, 0, 1'b0, res, acc, lat, re, se, ie);
        total++;
        if (res != 64'sd2097152) begin bad++; $display("FAIL neg_res: got %0d want 2097152", res); end
        total++;
        if (acc != 4 || lat != 3) begin bad++; $display("FAIL neg_accepts: got %0d lat %0d want 4 lat 3", acc, lat); end
    endtask

    task automatic test_max_gap();
        longint res; int acc, lat, re, se, ie;
        fill_const(1, -1);
        do_cmd(0, 1, 0, 1'b0, res, acc, lat, re, se, ie);
        total++;
        if (res != -64'sd2048) begin bad++; $display("FAIL max_res: got %0d want -2048", res); end
        total++;
        if (acc != 64 || re != 0) begin bad++; $display("FAIL max_accepts: got %0d rdyerr %0d want 64 0", acc, re); end
    endtask

    task automatic test_hold();
        longint res; int acc, lat, re, se, ie;
        fill_const(0, 0);
        for (int l = 0; l < K; l++) begin
            blk_a[0][l] = 8'sd3;  blk_b[0][l] = 8'sd5;
            blk_a[1][l] = -8'sd2; blk_b[1][l] = 8'sd7;
        end
        do_cmd(2, 0, 10, 1'b1, res, acc, lat, re, se, ie);
        total++;
        if (res != 64'sd32) begin bad++; $display("FAIL hold_res: got %0d want 32", res); end
        total++;
        if (se != 0 || ie != 0) begin bad++; $display("FAIL hold_stable: errs %0d/%0d want 0/0", se, ie); end
    endtask

    task automatic test_back_to_back();
        longint res, exp; int acc, lat, re, se, ie;
        for (int it = 0; it < 3; it++) begin
            fill_rand();
            do_cmd(3 + it, 0, 0, 1'b0, res, acc, lat, re, se, ie);
            exp = model_dot(3 + it);
            total++;
            if (res != exp || re != 0 || ie != 0) begin
                bad++;
                $display("FAIL b2b_res: got %0d want %0d (errs %0d/%0d)", res, exp, re, ie);
            end
        end
    endtask

    task automatic test_random();
        longint res, exp; int acc, lat, re, se, ie, n_enc, n;
        for (int it = 0; it < 8; it++) begin
            fill_rand();
            n_enc = $urandom_range(0, 63);
            if (it == 0) n_enc = 63;
            n = (n_enc == 0) ? MB : n_enc;
            do_cmd(n_enc, $urandom_range(0, 2), $urandom_range(0, 3), 1'b1, res, acc, lat, re, se, ie);
            exp = model_dot(n);
            total++;
            if (res != exp) begin bad++; $display("FAIL rand_res: n=%0d got %0d want %0d", n, res, exp); end
            total++;
            if (acc != n || lat != 3 || re != 0 || se != 0 || ie != 0) begin
                bad++;
                $display("FAIL rand_ctl: n=%0d accepts %0d lat %0d errs %0d/%0d/%0d want %0d 3 0/0/0",
                         n, acc, lat, re, se, ie, n);
            end
        end
    endtask

    task automatic test_abort();
        longint res; int acc, lat, re, se, ie;
        fill_const(5, 7);
        @(negedge i_clk);
        i_start = 1'b1;
        i_n_blocks = 6'd4;
        @(negedge i_clk);
        i_start = 1'b0;
        for (int b = 0; b < 2; b++) begin
            drive_ops(b, 1'b1);
            @(negedge i_clk);
        end
        #2 i_rst_n = 1'b0;
        #1;
        total++;
        if (o_busy !== 1'b0 || o_op_ready !== 1'b0 || o_res_valid !== 1'b0 || o_res !== '0) begin
            bad++;
            $display("FAIL abort_outputs: busy=%b ready=%b valid=%b res=%0d want all 0",
                     o_busy, o_op_ready, o_res_valid, o_res);
        end
        i_op_valid = 1'b0;
        @(negedge i_clk);
        i_rst_n = 1'b1;
        fill_const(2, 2);
        do_cmd(1, 0, 0, 1'b0, res, acc, lat, re, se, ie);
        total++;
        if (res != 64'sd128 || lat != 3) begin bad++; $display("FAIL abort_next: got %0d lat %0d want 128 lat 3", res, lat); end
    endtask

    initial begin
        test_reset();
        test_single();
        test_neg_full();
        test_max_gap();
        test_hold();
        test_back_to_back();
        test_random();
        test_abort();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
